mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between the instruction-fetch requester and the data load/store requester of the RV32I core.
- Sequences each memory transaction (arbitrate, issue, wait, respond) and returns read data and a one-cycle acknowledge to the winning requester.
- Data side has fixed priority, with a starvation limit that protects fetch.
- Honours the control unit's halt: no new fetches are granted once halt is seen.

---
 rtl/mem_port_arbiter_if.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory and status signals around mem_port_arbiter.
// slave = the arbiter; master = the requesters/memory/control side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  i_halt;
  logic                  i_if_req;
  logic [ADDR_W-1:0]     i_if_addr;
  logic                  o_if_ack;
  logic [DATA_W-1:0]     o_if_rdata;
  logic                  i_dm_req;
  logic                  i_dm_wr;
  logic [ADDR_W-1:0]     i_dm_addr;
  logic [DATA_W-1:0]     i_dm_wdata;
  logic [DATA_W/8-1:0]   i_dm_mask;
  logic                  o_dm_ack;
  logic [DATA_W-1:0]     o_dm_rdata;
  logic                  o_mem_req;
  logic                  o_mem_wr;
  logic [ADDR_W-1:0]     o_mem_addr;
  logic [DATA_W-1:0]     o_mem_wdata;
  logic [DATA_W/8-1:0]   o_mem_mask;
  logic                  i_mem_ready;
  logic                  i_mem_rvalid;
  logic [DATA_W-1:0]     i_mem_rdata;
  logic                  o_busy;
  logic                  o_halted;
  logic                  o_err;

  modport slave (
    input  i_halt, i_if_req, i_if_addr, i_dm_req, i_dm_wr, i_dm_addr, i_dm_wdata, i_dm_mask,
           i_mem_ready, i_mem_rvalid, i_mem_rdata,
    output o_if_ack, o_if_rdata, o_dm_ack, o_dm_rdata, o_mem_req, o_mem_wr, o_mem_addr,
           o_mem_wdata, o_mem_mask, o_busy, o_halted, o_err
  );

  modport master (
    output i_halt, i_if_req, i_if_addr, i_dm_req, i_dm_wr, i_dm_addr, i_dm_wdata, i_dm_mask,
           i_mem_ready, i_mem_rvalid, i_mem_rdata,
    input  o_if_ack, o_if_rdata, o_dm_ack, o_dm_rdata, o_mem_req, o_mem_wr, o_mem_addr,
           o_mem_wdata, o_mem_mask, o_busy, o_halted, o_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data load/store.
// Optional transaction watchdog: define MEM_PORT_ARBITER_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  parameter int TIMEOUT_CYC = 64,
`endif
  parameter int MAX_WAIT    = 4
) (
  input logic               i_clk,
  input logic               i_rst,
  mem_port_arbiter_if.slave bus
);
  // state | meaning
  // IDLE  | arbitrate eligible requesters, latch the winner's request
  // ISSUE | drive the memory request until the memory accepts it
  // WAIT  | read accepted, wait for read data
  // RESP  | one-cycle ack to the winner
  localparam int MASK_W = DATA_W / 8;
  localparam int SC_W   = $clog2(MAX_WAIT + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(MAX_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t              state_q, state_d;
  logic                win_dm_q, win_dm_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   mask_q, mask_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic [SC_W-1:0]     starve_q, starve_d;
  logic                if_elig, dm_elig, fetch_forced;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                err_q, err_d;
`endif

  always_comb begin
    state_d    = state_q;
    win_dm_d   = win_dm_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mask_d     = mask_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    starve_d   = starve_q;
    if_elig      = bus.i_if_req & ~bus.i_halt;
    dm_elig      = bus.i_dm_req;
    fetch_forced = if_elig & (starve_q == SC_MAX);
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    wd_d  = wd_q;
    err_d = err_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
        wd_d  = '0;
        err_d = 1'b0;
`endif
        if (if_elig | dm_elig) begin
          state_d = S_ISSUE;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
          wd_d = WD_W'(TIMEOUT_CYC - 1);
`endif
          if (dm_elig & ~fetch_forced) begin
            win_dm_d = 1'b1;
            wr_d     = bus.i_dm_wr;
            addr_d   = bus.i_dm_addr;
            wdata_d  = bus.i_dm_wdata;
            mask_d   = bus.i_dm_mask;
            // fetch lost while eligible; cannot exceed MAX_WAIT since it would have won
            if (if_elig) starve_d = starve_q + 1'b1;
          end else begin
            win_dm_d = 1'b0;
            wr_d     = 1'b0;
            addr_d   = bus.i_if_addr;
            wdata_d  = '0;
            mask_d   = '1;
            starve_d = '0;
          end
        end
      end
      S_ISSUE: if (bus.i_mem_ready) state_d = wr_q ? S_RESP : S_WAIT;
      S_WAIT: begin
        if (bus.i_mem_rvalid) begin
          state_d = S_RESP;
          if (win_dm_q) dm_rdata_d = bus.i_mem_rdata;
          else          if_rdata_d = bus.i_mem_rdata;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    // Down-counter runs through ISSUE and WAIT; terminal count forces RESP if no progress.
    if (state_q == S_ISSUE || state_q == S_WAIT) begin
      if (wd_q != '0) wd_d = wd_q - 1'b1;
      if (state_d == state_q && wd_q == '0) begin
        state_d = S_RESP;
        err_d   = 1'b1;
        if (!wr_q) begin
          if (win_dm_q) dm_rdata_d = '0;
          else          if_rdata_d = '0;
        end
      end
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= S_IDLE;
      win_dm_q   <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mask_q     <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      starve_q   <= '0;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
      wd_q       <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      win_dm_q   <= win_dm_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mask_q     <= mask_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      starve_q   <= starve_d;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
      wd_q       <= wd_d;
      err_q      <= err_d;
`endif
    end
  end

  assign bus.o_busy      = (state_q != S_IDLE);
  assign bus.o_halted    = bus.i_halt & (state_q == S_IDLE);
  assign bus.o_if_ack    = (state_q == S_RESP) & ~win_dm_q;
  assign bus.o_dm_ack    = (state_q == S_RESP) & win_dm_q;
  assign bus.o_if_rdata  = if_rdata_q;
  assign bus.o_dm_rdata  = dm_rdata_q;
  assign bus.o_mem_req   = (state_q == S_ISSUE);
  assign bus.o_mem_wr    = (state_q == S_ISSUE) & wr_q;
  assign bus.o_mem_addr  = addr_q;
  assign bus.o_mem_wdata = wdata_q;
  assign bus.o_mem_mask  = mask_q;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  assign bus.o_err       = (state_q == S_RESP) & err_q;
`else
  assign bus.o_err       = 1'b0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter with a transaction-level model
// of arbitration and a behavioural memory.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus.slave)
  );

  logic [31:0] gmem [16];
  int          rdy_max = 0, rv_max = 1, rdy_wait = 0, rv_left = 0;
  bit          rv_pend = 0, mem_silent = 0;
  logic [31:0] rv_data;

  task automatic idle_inputs();
    bus.i_halt = 0; bus.i_if_req = 0; bus.i_if_addr = '0;
    bus.i_dm_req = 0; bus.i_dm_wr = 0; bus.i_dm_addr = '0; bus.i_dm_wdata = '0; bus.i_dm_mask = '0;
    bus.i_mem_ready = 0; bus.i_mem_rvalid = 0; bus.i_mem_rdata = '0;
  endtask

  task automatic reset_dut();
    rst = 0; idle_inputs(); rv_pend = 0;
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  // One cycle of the behavioural memory: random ready delay, rvalid 1..rv_max cycles after ready.
  task automatic tick();
    int idx;
    @(negedge clk);
    bus.i_mem_ready = 0; bus.i_mem_rvalid = 0; bus.i_mem_rdata = $urandom();
    if (rv_pend) begin
      rv_left--;
      if (rv_left == 0) begin bus.i_mem_rvalid = 1; bus.i_mem_rdata = rv_data; rv_pend = 0; end
    end
    if (bus.o_mem_req) begin
      if (rdy_wait > 0) rdy_wait--;
      else begin
        bus.i_mem_ready = 1;
        idx = int'(bus.o_mem_addr[5:2]);
        if (bus.o_mem_wr) begin
          for (int b = 0; b < 4; b++)
            if (bus.o_mem_mask[b]) gmem[idx][8*b +: 8] = bus.o_mem_wdata[8*b +: 8];
        end else if (!mem_silent) begin
          rv_pend = 1; rv_left = $urandom_range(1, rv_max); rv_data = gmem[idx];
        end
      end
    end else rdy_wait = $urandom_range(0, rdy_max);
  endtask

  task automatic test_reset();
    rst = 0; idle_inputs();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.o_if_ack, bus.o_dm_ack, bus.o_if_rdata, bus.o_dm_rdata, bus.o_mem_req, bus.o_mem_wr,
         bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_mask, bus.o_busy, bus.o_halted, bus.o_err} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got nonzero output vector, required all 0");
    end
    rst = 1;
  endtask

  task automatic test_fetch_read();
    @(negedge clk);
    n_checks++;
    if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL fetch_idle: busy=%b required 0", bus.o_busy); end
    bus.i_if_req = 1; bus.i_if_addr = 32'h10;
    @(negedge clk);
    n_checks++;
    if ({bus.o_mem_req, bus.o_mem_wr, bus.o_mem_addr, bus.o_mem_mask} !== {1'b1, 1'b0, 32'h10, 4'hF}) begin
      n_fail++; $display("FAIL fetch_issue: req=%b wr=%b addr=%h mask=%h required 1 0 00000010 f",
                         bus.o_mem_req, bus.o_mem_wr, bus.o_mem_addr, bus.o_mem_mask);
    end
    bus.i_mem_ready = 1;
    @(negedge clk);
    bus.i_mem_ready = 0;
    n_checks++;
    if (bus.o_mem_req !== 1'b0 || bus.o_if_ack !== 1'b0) begin
      n_fail++; $display("FAIL fetch_wait: req=%b ack=%b required 0 0", bus.o_mem_req, bus.o_if_ack);
    end
    bus.i_mem_rvalid = 1; bus.i_mem_rdata = 32'h0050_0093;
    @(negedge clk);
    bus.i_mem_rvalid = 0; bus.i_mem_rdata = '0;
    n_checks++;
    if ({bus.o_if_ack, bus.o_dm_ack, bus.o_if_rdata} !== {1'b1, 1'b0, 32'h0050_0093}) begin
      n_fail++; $display("FAIL fetch_ack: if_ack=%b dm_ack=%b rdata=%h required 1 0 00500093",
                         bus.o_if_ack, bus.o_dm_ack, bus.o_if_rdata);
    end
    bus.i_if_req = 0;
    @(negedge clk);
    n_checks++;
    if (bus.o_if_ack !== 1'b0 || bus.o_busy !== 1'b0) begin
      n_fail++; $display("FAIL fetch_after: ack=%b busy=%b required 0 0", bus.o_if_ack, bus.o_busy);
    end
  endtask

  task automatic test_store_delay();
    bus.i_dm_req = 1; bus.i_dm_wr = 1; bus.i_dm_addr = 32'h100;
    bus.i_dm_wdata = 32'hDEAD_BEEF; bus.i_dm_mask = 4'hF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.o_mem_req, bus.o_mem_wr, bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_mask, bus.o_dm_ack} !==
          {1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 1'b0}) begin
        n_fail++; $display("FAIL store_hold[%0d]: req=%b wr=%b addr=%h wdata=%h mask=%h ack=%b required 1 1 100 deadbeef f 0",
                           k, bus.o_mem_req, bus.o_mem_wr, bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_mask, bus.o_dm_ack);
      end
      bus.i_mem_ready = (k == 3);
    end
    @(negedge clk);
    bus.i_mem_ready = 0;
    n_checks++;
    if ({bus.o_dm_ack, bus.o_if_ack, bus.o_if_rdata} !== {1'b1, 1'b0, 32'h0050_0093}) begin
      n_fail++; $display("FAIL store_ack: dm_ack=%b if_ack=%b if_rdata=%h required 1 0 00500093",
                         bus.o_dm_ack, bus.o_if_ack, bus.o_if_rdata);
    end
    bus.i_dm_req = 0; bus.i_dm_wr = 0;
    @(negedge clk);
    n_checks++;
    if (bus.o_dm_ack !== 1'b0 || bus.o_busy !== 1'b0) begin
      n_fail++; $display("FAIL store_after: ack=%b busy=%b required 0 0", bus.o_dm_ack, bus.o_busy);
    end
  endtask

  task automatic test_reset_mid();
    bus.i_dm_req = 1; bus.i_dm_wr = 0; bus.i_dm_addr = 32'h18;
    @(negedge clk);
    n_checks++;
    if (bus.o_mem_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_issue: req=%b required 1", bus.o_mem_req); end
    bus.i_mem_ready = 1;
    @(negedge clk);
    bus.i_mem_ready = 0;
    rst = 0; bus.i_dm_req = 0;
    #1;
    n_checks++;
    if ({bus.o_if_ack, bus.o_dm_ack, bus.o_if_rdata, bus.o_dm_rdata, bus.o_mem_req, bus.o_mem_wr,
         bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_mask, bus.o_busy, bus.o_halted, bus.o_err} !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs: if_rdata=%h busy=%b required all 0", bus.o_if_rdata, bus.o_busy);
    end
    @(negedge clk);
    rst = 1; bus.i_mem_rvalid = 1; bus.i_mem_rdata = 32'h1234_5678;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.i_mem_rvalid = 0;
      n_checks++;
      if ({bus.o_dm_ack, bus.o_if_ack, bus.o_busy, bus.o_dm_rdata} !== '0) begin
        n_fail++; $display("FAIL rstmid_ignore[%0d]: dm_ack=%b if_ack=%b busy=%b dm_rdata=%h required 0 0 0 0",
                           k, bus.o_dm_ack, bus.o_if_ack, bus.o_busy, bus.o_dm_rdata);
      end
    end
    bus.i_if_req = 1; bus.i_if_addr = 32'h20;
    @(negedge clk);
    n_checks++;
    if ({bus.o_mem_req, bus.o_mem_addr} !== {1'b1, 32'h20}) begin
      n_fail++; $display("FAIL rstmid_next_issue: req=%b addr=%h required 1 00000020", bus.o_mem_req, bus.o_mem_addr);
    end
    bus.i_mem_ready = 1;
    @(negedge clk);
    bus.i_mem_ready = 0; bus.i_mem_rvalid = 1; bus.i_mem_rdata = 32'hCAFE_0001;
    @(negedge clk);
    bus.i_mem_rvalid = 0; bus.i_if_req = 0;
    n_checks++;
    if ({bus.o_if_ack, bus.o_if_rdata} !== {1'b1, 32'hCAFE_0001}) begin
      n_fail++; $display("FAIL rstmid_next_ack: ack=%b rdata=%h required 1 cafe0001", bus.o_if_ack, bus.o_if_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_starvation();
    string exp_order = "DDDDFDDDDF";
    int    acks = 0, cyc = 0;
    byte   got;
    reset_dut(); rdy_max = 0; rv_max = 1;
    bus.i_if_req = 1; bus.i_if_addr = 32'h4;
    bus.i_dm_req = 1; bus.i_dm_wr = 0; bus.i_dm_addr = 32'h8;
    while (acks < 10 && cyc < 300) begin
      tick(); cyc++;
      if (bus.o_if_ack || bus.o_dm_ack) begin
        got = bus.o_dm_ack ? "D" : "F";
        n_checks++;
        if ((bus.o_if_ack && bus.o_dm_ack) || got != exp_order[acks]) begin
          n_fail++; $display("FAIL starve_order[%0d]: got %s required %s", acks, string'(got), string'(exp_order[acks]));
        end
        n_checks++;
        if (bus.o_dm_ack ? (bus.o_dm_rdata !== gmem[2]) : (bus.o_if_rdata !== gmem[1])) begin
          n_fail++; $display("FAIL starve_rdata[%0d]: dm=%h if=%h required %h / %h",
                             acks, bus.o_dm_rdata, bus.o_if_rdata, gmem[2], gmem[1]);
        end
        acks++;
      end
    end
    n_checks++;
    if (acks < 10) begin n_fail++; $display("FAIL starve_timeout: got %0d acks required 10", acks); end
    bus.i_if_req = 0; bus.i_dm_req = 0;
    repeat (6) tick();
  endtask

  task automatic test_halt();
    int  t, dm_acks = 0;
    bit  seen = 0;
    reset_dut(); rdy_max = 1; rv_max = 2;
    bus.i_if_req = 1; bus.i_if_addr = 32'hC;
    tick();
    bus.i_halt = 1;
    for (t = 0; t < 20 && !seen; t++) begin
      tick();
      if (bus.o_if_ack) seen = 1;
    end
    n_checks++;
    if (!seen || bus.o_if_rdata !== gmem[3]) begin
      n_fail++; $display("FAIL halt_inflight_fetch: seen=%b rdata=%h required 1 %h", seen, bus.o_if_rdata, gmem[3]);
    end
    bus.i_dm_req = 1; bus.i_dm_wr = 0; bus.i_dm_addr = 32'h14;
    for (int k = 0; k < 40; k++) begin
      tick();
      n_checks++;
      if (bus.o_if_ack !== 1'b0) begin n_fail++; $display("FAIL halt_fetch_granted: if_ack=%b required 0", bus.o_if_ack); end
      n_checks++;
      if (bus.o_halted !== !bus.o_busy) begin
        n_fail++; $display("FAIL halt_flag: halted=%b busy=%b required halted = not busy", bus.o_halted, bus.o_busy);
      end
      if (bus.o_dm_ack) dm_acks++;
    end
    n_checks++;
    if (dm_acks < 3) begin n_fail++; $display("FAIL halt_data_served: got %0d acks required >= 3", dm_acks); end
    seen = 0;
    for (t = 0; t < 20 && !seen; t++) begin
      tick();
      if (bus.o_dm_ack) begin seen = 1; bus.i_dm_req = 0; bus.i_halt = 0; end
    end
    seen = 0;
    for (t = 0; t < 20 && !seen; t++) begin
      tick();
      if (bus.o_if_ack || bus.o_dm_ack) begin
        seen = 1;
        n_checks++;
        if (bus.o_if_ack !== 1'b1 || bus.o_if_rdata !== gmem[3]) begin
          n_fail++; $display("FAIL halt_release: if_ack=%b rdata=%h required 1 %h", bus.o_if_ack, bus.o_if_rdata, gmem[3]);
        end
        bus.i_if_req = 0;
      end
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL halt_release_timeout: no ack, required fetch ack"); end
    repeat (4) tick();
  endtask

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    int t = 0;
    bit seen = 0;
    reset_dut(); rdy_max = 0; rv_max = 1; mem_silent = 1;
    bus.i_dm_req = 1; bus.i_dm_wr = 0; bus.i_dm_addr = 32'h28;
    while (!seen && t < 100) begin
      tick(); t++;
      if (bus.o_dm_ack) begin
        seen = 1;
        n_checks++;
        if (t != 65 || bus.o_err !== 1'b1 || bus.o_dm_rdata !== '0) begin
          n_fail++; $display("FAIL timeout_ack: cycle=%0d err=%b rdata=%h required 65 1 0", t, bus.o_err, bus.o_dm_rdata);
        end
        bus.i_dm_req = 0;
      end
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL timeout_hang: no ack within 100 cycles, required ack at 65"); end
    mem_silent = 0;
    repeat (3) tick();
  endtask
`endif

  task automatic test_random();
    bit          if_act = 0, dm_act = 0, if_drop = 0, dm_drop = 0;
    logic [31:0] if_a = '0, dm_a = '0, dm_wd = '0;
    logic        dm_w = 0;
    logic [3:0]  dm_m = '0;
    bit          arb_free = 1, free_next, exp_act = 0, exp_dm = 0, exp_w = 0, gen, ife, dme;
    logic [31:0] exp_addr = '0, exp_wd = '0, exp_rd = '0, exp_if_rd = '0, exp_dm_rd = '0;
    logic [3:0]  exp_m = '0;
    int          starve = 0, c = 0;
    reset_dut(); rdy_max = 2; rv_max = 3;
    while ((c < 1500 || if_act || dm_act || !arb_free) && c < 2000) begin
      gen = (c < 1500);
      tick(); c++;
      free_next = 0;
      if (bus.o_if_ack || bus.o_dm_ack) begin
        n_checks++;
        if (!exp_act || {bus.o_if_ack, bus.o_dm_ack} !== {~exp_dm, exp_dm}) begin
          n_fail++; $display("FAIL rnd_ack_owner: if_ack=%b dm_ack=%b required dm_winner=%b active=%b",
                             bus.o_if_ack, bus.o_dm_ack, exp_dm, exp_act);
        end
        if (exp_act && !exp_w) begin
          if (exp_dm) exp_dm_rd = exp_rd; else exp_if_rd = exp_rd;
        end
        if (exp_dm) begin dm_act = 0; dm_drop = 0; end else begin if_act = 0; if_drop = 0; end
        exp_act = 0; free_next = 1;
      end
      n_checks++;
      if (bus.o_if_rdata !== exp_if_rd) begin n_fail++; $display("FAIL rnd_if_rdata: got %h required %h", bus.o_if_rdata, exp_if_rd); end
      n_checks++;
      if (bus.o_dm_rdata !== exp_dm_rd) begin n_fail++; $display("FAIL rnd_dm_rdata: got %h required %h", bus.o_dm_rdata, exp_dm_rd); end
      n_checks++;
      if (bus.o_busy !== !arb_free) begin n_fail++; $display("FAIL rnd_busy: got %b required %b", bus.o_busy, !arb_free); end
      n_checks++;
      if (bus.o_halted !== (bus.i_halt & arb_free)) begin
        n_fail++; $display("FAIL rnd_halted: got %b required %b", bus.o_halted, bus.i_halt & arb_free);
      end
      n_checks++;
      if (bus.o_err !== 1'b0) begin n_fail++; $display("FAIL rnd_err: got %b required 0", bus.o_err); end
      if (bus.o_mem_req) begin
        n_checks++;
        if (!exp_act || bus.o_mem_addr !== exp_addr || bus.o_mem_wr !== exp_w || bus.o_mem_mask !== exp_m ||
            (exp_w && bus.o_mem_wdata !== exp_wd)) begin
          n_fail++; $display("FAIL rnd_mem_port: addr=%h wr=%b mask=%h wdata=%h required %h %b %h %h",
                             bus.o_mem_addr, bus.o_mem_wr, bus.o_mem_mask, bus.o_mem_wdata, exp_addr, exp_w, exp_m, exp_wd);
        end
      end
      if (gen && !if_act && $urandom_range(0, 2) == 0) begin
        if_act = 1; if_a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      end
      if (gen && !dm_act && $urandom_range(0, 2) == 0) begin
        dm_act = 1; dm_w = 1'($urandom_range(0, 1)); dm_a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        dm_wd = $urandom(); dm_m = 4'($urandom_range(0, 15));
      end
      // a granted requester may drop its line early; the transaction must still complete
      if (exp_act && $urandom_range(0, 7) == 0) begin
        if (exp_dm) dm_drop = 1; else if_drop = 1;
      end
      if (!gen) bus.i_halt = 0;
      else if ($urandom_range(0, 40) == 0) bus.i_halt = !bus.i_halt;
      bus.i_if_req = if_act & ~if_drop; bus.i_if_addr = if_a;
      bus.i_dm_req = dm_act & ~dm_drop; bus.i_dm_wr = dm_w; bus.i_dm_addr = dm_a;
      bus.i_dm_wdata = dm_wd; bus.i_dm_mask = dm_m;
      if (arb_free) begin
        ife = bus.i_if_req && !bus.i_halt;
        dme = bus.i_dm_req;
        if (ife || dme) begin
          exp_dm = dme && !(ife && starve == MW);
          if (exp_dm) begin
            if (ife) starve = (starve < MW) ? starve + 1 : MW;
            exp_addr = dm_a; exp_w = dm_w; exp_wd = dm_wd; exp_m = dm_m;
          end else begin
            starve = 0;
            exp_addr = if_a; exp_w = 0; exp_wd = '0; exp_m = 4'hF;
          end
          exp_rd = gmem[int'(exp_addr[5:2])];
          exp_act = 1; arb_free = 0;
        end
      end
      if (free_next) arb_free = 1;
    end
    n_checks++;
    if (if_act || dm_act || !arb_free) begin
      n_fail++; $display("FAIL rnd_drain: if_act=%b dm_act=%b free=%b required 0 0 1", if_act, dm_act, arb_free);
    end
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    for (int i = 0; i < 16; i++) gmem[i] = $urandom();
    test_reset();
    test_fetch_read();
    test_store_delay();
    test_reset_mid();
    test_starvation();
    test_halt();
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded 500000 time units");
    $fatal(1, "global timeout");
  end
endmodule
